// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: D-stage RAW / HI-LO hazard stall, ID/EX clear and forward selects, plus the mult/div busy FSM.
// Latency: stall and forward selects are combinational; md_busy follows md_start_E by one cycle. Optional HAZARD_STATS_EN adds stall counters.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_use_D,
    input  logic [4:0]  a3_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  a3_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        stall,
    output logic        clr_de,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic        md_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] md_stall_cnt
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic rs_hit_e, rs_hit_m, rt_hit_e, rt_hit_m;
    logic reg_hz, md_hz;

    // Register 0 is hardwired, so it never produces a dependency.
    assign rs_hit_e = (rs_D != 5'd0) && (rs_D == a3_E);
    assign rs_hit_m = (rs_D != 5'd0) && (rs_D == a3_M);
    assign rt_hit_e = (rt_D != 5'd0) && (rt_D == a3_E);
    assign rt_hit_m = (rt_D != 5'd0) && (rt_D == a3_M);

    assign reg_hz = (rs_hit_e && (tuse_rs_D < tnew_E)) ||
                    (rs_hit_m && (tuse_rs_D < tnew_M)) ||
                    (rt_hit_e && (tuse_rt_D < tnew_E)) ||
                    (rt_hit_m && (tuse_rt_D < tnew_M));

    assign md_busy = (state_q == BUSY);
    assign md_hz   = md_use_D && (md_busy || md_start_E);
    assign stall   = reg_hz || md_hz;
    assign clr_de  = stall;

    always_comb begin
        fwd_rs_D = 2'd0;
        fwd_rt_D = 2'd0;
        if (rs_hit_e && (tnew_E == 2'd0))      fwd_rs_D = 2'd1;
        else if (rs_hit_m && (tnew_M == 2'd0)) fwd_rs_D = 2'd2;
        if (rt_hit_e && (tnew_E == 2'd0))      fwd_rt_D = 2'd1;
        else if (rt_hit_m && (tnew_M == 2'd0)) fwd_rt_D = 2'd2;
    end

    // A start while BUSY reloads the count so the new op gets its full latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_start_E) begin
                    state_d = BUSY;
                    cnt_d   = md_is_div_E ? DIV_CNT : MULT_CNT;
                end
            end
            BUSY: begin
                if (md_start_E) begin
                    cnt_d = md_is_div_E ? DIV_CNT : MULT_CNT;
                end else if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

    // Both counters wrap naturally at 32 bits.
    always_comb begin
        stall_cnt_d    = stall_cnt_q + 32'(stall);
        md_stall_cnt_d = md_stall_cnt_q + 32'(md_hz);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= 32'd0;
            md_stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            md_stall_cnt_q <= md_stall_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign md_stall_cnt = md_stall_cnt_q;
`else
    assign stall_cnt    = 32'd0;
    assign md_stall_cnt = 32'd0;
`endif

endmodule
